// File: rtl/zipdbg_pkg.sv
// Shared definitions for the ZipCPU debug command sequencer: op codes,
// debug control-word bit positions, FSM state encoding.
package zipdbg_pkg;

  typedef enum logic [1:0] {
    OP_RD_REG  = 2'd0,
    OP_WR_REG  = 2'd1,
    OP_WR_CTRL = 2'd2,
    OP_RD_CTRL = 2'd3
  } zipdbg_op_e;

  localparam logic [31:0] CTRL_ADDR_MASK  = 32'h0000_001f;
  localparam int          CTRL_RESET_BIT  = 6;
  localparam int          CTRL_STEP_BIT   = 8;
  localparam int          CTRL_HALT_BIT   = 10;
  localparam int          CTRL_CLRCACHE_BIT = 11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CTRL_RD   = 3'd1,
    S_ADDR_WR   = 3'd2,
    S_DATA_XFER = 3'd3,
    S_RESUME_WR = 3'd4,
    S_RESP      = 3'd5
  } zipdbg_state_e;

  // Control word selecting register regidx, optionally with the halt bit set.
  function automatic logic [31:0] ctrl_word(input logic halt, input logic [4:0] regidx);
    logic [31:0] w;
    w = {27'h0, regidx} & CTRL_ADDR_MASK;
    w[CTRL_HALT_BIT] = halt;
    return w;
  endfunction

endpackage

// File: rtl/zipdbg_wbtimer.sv
// Debug-bus ack timeout: reloads on restart, counts down while a request is
// pending, and flags expiry on the cycle the 2^LGTIMEOUT-1 budget runs out.
module zipdbg_wbtimer #(
  parameter int LGTIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [LGTIMEOUT-1:0] TMAX = '1;
  localparam logic [LGTIMEOUT-1:0] ONE  = LGTIMEOUT'(1);

  logic [LGTIMEOUT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_restart) begin
      cnt_d = TMAX;
    end else if (i_run && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= TMAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: this edge would complete the full budget of waiting cycles.
  assign o_expired = i_run && !i_restart && (cnt_q == ONE);

endmodule

// File: rtl/zipdbg_bridge.sv
// Expands register-level debug commands into ZipCPU debug-port transactions.
// Optional auto-resume (read halt state first, restore run state after) via ZIPDBG_AUTO_RESUME_EN.
module zipdbg_bridge
  import zipdbg_pkg::*;
#(
  parameter int LGTIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_stb,
  input  logic [1:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_reg,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_busy,
  output logic        o_rsp_stb,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_dbg_cyc,
  output logic        o_dbg_stb,
  output logic        o_dbg_we,
  output logic        o_dbg_addr,
  output logic [31:0] o_dbg_data,
  input  logic        i_dbg_ack,
  input  logic        i_dbg_stall,
  input  logic [31:0] i_dbg_data
);

  zipdbg_state_e state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, data_q, data_d;
  logic        outst_q, outst_d, err_q, err_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  reg_q, reg_d;
  logic        issue, xfer_done, expired, timed_out;
`ifdef ZIPDBG_AUTO_RESUME_EN
  logic        halted_q, halted_d;
`endif

  zipdbg_wbtimer #(.LGTIMEOUT(LGTIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (issue),
    .i_run     (stb_q | outst_q),
    .o_expired (expired)
  );

  // An ack only counts while a request is actually outstanding.
  assign xfer_done = outst_q & i_dbg_ack;
  assign timed_out = expired & ~xfer_done;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    outst_d = outst_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    op_d    = op_q;
    reg_d   = reg_q;
    data_d  = data_q;
    issue   = 1'b0;
`ifdef ZIPDBG_AUTO_RESUME_EN
    halted_d = halted_q;
`endif

    if (stb_q && !i_dbg_stall) begin
      stb_d   = 1'b0;
      outst_d = 1'b1;
    end
    if (xfer_done) begin
      outst_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_cmd_stb) begin
          op_d    = i_cmd_op;
          reg_d   = i_cmd_reg;
          data_d  = i_cmd_data;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          addr_d  = 1'b0;
          issue   = 1'b1;
          case (zipdbg_op_e'(i_cmd_op))
            OP_RD_REG, OP_WR_REG: begin
`ifdef ZIPDBG_AUTO_RESUME_EN
              state_d = S_CTRL_RD;
              we_d    = 1'b0;
              wdata_d = 32'h0;
`else
              state_d = S_ADDR_WR;
              we_d    = 1'b1;
              wdata_d = ctrl_word(1'b1, i_cmd_reg);
`endif
            end
            OP_WR_CTRL: begin
              state_d = S_DATA_XFER;
              we_d    = 1'b1;
              wdata_d = i_cmd_data;
            end
            default: begin
              state_d = S_DATA_XFER;
              we_d    = 1'b0;
              wdata_d = i_cmd_data;
            end
          endcase
        end
      end
`ifdef ZIPDBG_AUTO_RESUME_EN
      S_CTRL_RD: begin
        if (xfer_done) begin
          halted_d = i_dbg_data[CTRL_HALT_BIT];
          state_d  = S_ADDR_WR;
          stb_d    = 1'b1;
          we_d     = 1'b1;
          addr_d   = 1'b0;
          wdata_d  = ctrl_word(1'b1, reg_q);
          issue    = 1'b1;
        end
      end
`endif
      S_ADDR_WR: begin
        if (xfer_done) begin
          state_d = S_DATA_XFER;
          stb_d   = 1'b1;
          we_d    = (op_q == OP_WR_REG);
          addr_d  = 1'b1;
          wdata_d = data_q;
          issue   = 1'b1;
        end
      end
      S_DATA_XFER: begin
        if (xfer_done) begin
          if (!we_q) begin
            rdata_d = i_dbg_data;
          end
          state_d = S_RESP;
          cyc_d   = 1'b0;
`ifdef ZIPDBG_AUTO_RESUME_EN
          // Only a CPU we halted ourselves gets released again.
          if (!op_q[1] && !halted_q) begin
            state_d = S_RESUME_WR;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = 1'b0;
            wdata_d = ctrl_word(1'b0, reg_q);
            issue   = 1'b1;
          end
`endif
        end
      end
`ifdef ZIPDBG_AUTO_RESUME_EN
      S_RESUME_WR: begin
        if (xfer_done) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
        end
      end
`endif
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    if (timed_out) begin
      state_d = S_RESP;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      outst_d = 1'b0;
      err_d   = 1'b1;
      rdata_d = 32'h0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 1'b0;
      wdata_q <= 32'h0;
      outst_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      op_q    <= 2'd0;
      reg_q   <= 5'd0;
      data_q  <= 32'h0;
`ifdef ZIPDBG_AUTO_RESUME_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      outst_q <= outst_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      op_q    <= op_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
`ifdef ZIPDBG_AUTO_RESUME_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign o_cmd_busy = (state_q != S_IDLE);
  assign o_rsp_stb  = (state_q == S_RESP);
  assign o_rsp_data = o_rsp_stb ? rdata_q : 32'h0;
  assign o_rsp_err  = o_rsp_stb & err_q;
  assign o_dbg_cyc  = cyc_q;
  assign o_dbg_stb  = stb_q;
  assign o_dbg_we   = we_q;
  assign o_dbg_addr = addr_q;
  assign o_dbg_data = wdata_q;

endmodule

// File: tb/tb_zipdbg_bridge.sv
// Directed bench for zipdbg_bridge with a scoreboarded debug-slave model.
// Also covers the ZIPDBG_AUTO_RESUME_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_zipdbg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_stb = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_reg = 5'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_busy, rsp_stb, rsp_err;
  logic [31:0] rsp_data;
  logic        dbg_cyc, dbg_stb, dbg_we, dbg_addr, dbg_stall;
  logic [31:0] dbg_data;
  logic        slv_ack = 1'b0;
  logic [31:0] slv_dat = 32'h0;

  int total = 0;
  int bad   = 0;

  // {we, addr, write data (0 for reads)}
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  int          stall_left = 0;
  logic        spur_req = 1'b0;
  logic        mute = 1'b0;
  logic [31:0] ctrl_val = 32'h0;
  logic [31:0] data_val = 32'h0;

  always #5 clk = ~clk;

  zipdbg_bridge #(.LGTIMEOUT(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_stb  (cmd_stb),
    .i_cmd_op   (cmd_op),
    .i_cmd_reg  (cmd_reg),
    .i_cmd_data (cmd_data),
    .o_cmd_busy (cmd_busy),
    .o_rsp_stb  (rsp_stb),
    .o_rsp_data (rsp_data),
    .o_rsp_err  (rsp_err),
    .o_dbg_cyc  (dbg_cyc),
    .o_dbg_stb  (dbg_stb),
    .o_dbg_we   (dbg_we),
    .o_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_dbg_ack  (slv_ack),
    .i_dbg_stall(dbg_stall),
    .i_dbg_data (slv_dat)
  );

  // Stalls only apply to data-register requests.
  assign dbg_stall = dbg_stb && (stall_left > 0) && dbg_addr;

  always @(posedge clk) begin
    slv_ack <= 1'b0;
    if (rst) begin
      slv_dat <= 32'h0;
    end else if (dbg_cyc && dbg_stb && dbg_stall) begin
      stall_left = stall_left - 1;
      if (spur_req) begin
        slv_ack <= 1'b1;
        slv_dat <= 32'hBAD0_BAD0;
        spur_req = 1'b0;
      end
    end else if (dbg_cyc && dbg_stb) begin
      obs_q.push_back({dbg_we, dbg_addr, dbg_we ? dbg_data : 32'h0});
      if (!mute) begin
        slv_ack <= 1'b1;
        slv_dat <= dbg_we ? 32'h0 : (dbg_addr ? data_val : ctrl_val);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op, input int stalls);
    int l;
    l = (op < 2'd2) ? 4 : 2;
`ifdef ZIPDBG_AUTO_RESUME_EN
    if (op < 2'd2) l += ctrl_val[10] ? 2 : 4;
`endif
    return l + stalls;
  endfunction

  task automatic expect_cmd(input logic [1:0] op, input logic [4:0] r, input logic [31:0] d);
    if (op < 2'd2) begin
`ifdef ZIPDBG_AUTO_RESUME_EN
      exp_q.push_back({1'b0, 1'b0, 32'h0});
`endif
      exp_q.push_back({1'b1, 1'b0, 32'h0000_0400 | {27'h0, r}});
      exp_q.push_back({op == 2'd1, 1'b1, (op == 2'd1) ? d : 32'h0});
`ifdef ZIPDBG_AUTO_RESUME_EN
      if (!ctrl_val[10]) exp_q.push_back({1'b1, 1'b0, {27'h0, r}});
`endif
    end else begin
      exp_q.push_back({op == 2'd2, 1'b0, (op == 2'd2) ? d : 32'h0});
    end
  endtask

  task automatic check_bus(input string tag);
    logic [33:0] e, o;
    check({tag, "_ntx"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_we"},   {31'h0, o[33]}, {31'h0, e[33]});
      check({tag, "_addr"}, {31'h0, o[32]}, {31'h0, e[32]});
      check({tag, "_wdat"}, o[31:0], e[31:0]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Issue one command at a negedge; hold_stb keeps i_cmd_stb asserted (with a
  // scrambled op) until the response to show busy-time strobes are dropped.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [4:0] r,
                         input logic [31:0] d, input int exp_lat,
                         input logic [31:0] exp_data, input logic exp_err, input bit hold_stb);
    int n;
    bit seen;
    @(negedge clk);
    cmd_stb = 1'b1; cmd_op = op; cmd_reg = r; cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    if (hold_stb) begin
      cmd_op = ~op; cmd_reg = ~r; cmd_data = ~d;
    end else begin
      cmd_stb = 1'b0;
    end
    check({tag, "_busy"}, {31'h0, cmd_busy}, 32'h1);
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      if (rsp_stb) begin
        seen = 1;
      end else begin
        if (dbg_stall && dbg_we && dbg_addr) check({tag, "_stall_hold"}, dbg_data, d);
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    cmd_stb = 1'b0;
    check({tag, "_rsp_seen"}, {31'h0, seen}, 32'h1);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rsp_1cyc"}, {31'h0, rsp_stb}, 32'h0);
    check({tag, "_idle"}, {31'h0, cmd_busy}, 32'h0);
    check_bus(tag);
  endtask

  initial begin
    int n;
    bit reached, late_rsp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, cmd_busy}, 32'h0);
    check("rst_rsp",  {31'h0, rsp_stb}, 32'h0);
    check("rst_cyc",  {31'h0, dbg_cyc}, 32'h0);
    check("rst_stb",  {31'h0, dbg_stb}, 32'h0);
    check("rst_bus",  {29'h0, dbg_we, dbg_addr, rsp_err}, 32'h0);
    check("rst_wdat", dbg_data, 32'h0);
    check("rst_rdat", rsp_data, 32'h0);
    rst = 1'b0;

    // Register read, CPU running
    ctrl_val = 32'h0;
    data_val = 32'hDEAD_BEEF;
    expect_cmd(2'd0, 5'd5, 32'h0);
    run_cmd("rd_r5", 2'd0, 5'd5, 32'h0, lat_of(2'd0, 0), 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Register write, data stalled twice, spurious ack inside the stall
    stall_left = 2;
    spur_req = 1'b1;
    expect_cmd(2'd1, 5'd3, 32'h1234_5678);
    run_cmd("wr_r3", 2'd1, 5'd3, 32'h1234_5678, lat_of(2'd1, 2), 32'h0, 1'b0, 1'b0);
    check("spur_used", {31'h0, spur_req}, 32'h0);

    // Highest register index
    data_val = 32'h0BAD_F00D;
    expect_cmd(2'd0, 5'd31, 32'h0);
    run_cmd("rd_r31", 2'd0, 5'd31, 32'h0, lat_of(2'd0, 0), 32'h0BAD_F00D, 1'b0, 1'b0);

    // Raw control write / control read
    expect_cmd(2'd2, 5'd0, 32'h0000_0940);
    run_cmd("wr_ctl", 2'd2, 5'd0, 32'h0000_0940, lat_of(2'd2, 0), 32'h0, 1'b0, 1'b0);
    ctrl_val = 32'h0000_0C00;
    expect_cmd(2'd3, 5'd0, 32'h0);
    run_cmd("rd_ctl", 2'd3, 5'd0, 32'h0, lat_of(2'd3, 0), 32'h0000_0C00, 1'b0, 1'b0);

    // Timeout: slave never acks, 15 cycles with LGTIMEOUT=4
    mute = 1'b1;
    expect_cmd(2'd3, 5'd0, 32'h0);
    run_cmd("tmo", 2'd3, 5'd0, 32'h0, 15, 32'h0, 1'b1, 1'b0);
    check("tmo_cyc", {31'h0, dbg_cyc}, 32'h0);
    mute = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during the data-register access
    ctrl_val = 32'h0;
    @(negedge clk);
    cmd_stb = 1'b1; cmd_op = 2'd1; cmd_reg = 5'd7; cmd_data = 32'hCAFE_0007;
    @(posedge clk);
    @(negedge clk);
    cmd_stb = 1'b0;
    n = 0;
    reached = 0;
    while (!reached && n < 50) begin
      if (dbg_stb && dbg_addr) reached = 1;
      else begin @(posedge clk); n++; @(negedge clk); end
    end
    check("mid_reached", {31'h0, reached}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_cyc",  {31'h0, dbg_cyc}, 32'h0);
    check("mid_stb",  {31'h0, dbg_stb}, 32'h0);
    check("mid_busy", {31'h0, cmd_busy}, 32'h0);
    rst = 1'b0;
    late_rsp = 0;
    repeat (8) begin
      if (rsp_stb) late_rsp = 1;
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_no_rsp", {31'h0, late_rsp}, 32'h0);
    exp_q.delete();
    obs_q.delete();

    // Normal command after reset, with i_cmd_stb held high throughout
    expect_cmd(2'd2, 5'd0, 32'h0000_0015);
    run_cmd("post_rst", 2'd2, 5'd0, 32'h0000_0015, lat_of(2'd2, 0), 32'h0, 1'b0, 1'b1);

`ifdef ZIPDBG_AUTO_RESUME_EN
    // CPU already halted: no resume write
    ctrl_val = 32'h0000_0400;
    data_val = 32'h5555_AAAA;
    expect_cmd(2'd0, 5'd9, 32'h0);
    run_cmd("halted_rd", 2'd0, 5'd9, 32'h0, lat_of(2'd0, 0), 32'h5555_AAAA, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
